// File: rtl/mem_stream_reader_pkg.sv
// mem_stream_reader_pkg: shared state type and width helpers for the stream reader
package mem_stream_reader_pkg;
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  function automatic int addr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction
  function automatic int cnt_w(input int d);
    return $clog2(d) + 1;
  endfunction
endpackage

// File: rtl/mem_stream_reader_sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count and active-low sync reset
module sync_fifo
  import mem_stream_reader_pkg::*;
#(
  parameter int width = 33,
  parameter int depth = 4,
  localparam int AW = addr_w(depth),
  localparam int CW = cnt_w(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic [width-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  logic [width-1:0] mem [depth];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign empty = count == '0;
  assign full = count == CW'(depth);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_stream_reader.sv
// mem_stream_reader: sequential memory reader feeding a credit-limited valid/ready stream
module mem_stream_reader
  import mem_stream_reader_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 256,
  parameter int fifo_depth = 4,
  localparam int AW = addr_w(depth),
  localparam int LW = AW + 1,
  localparam int CW = cnt_w(fifo_depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [LW-1:0]    length,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd_en,
  input  logic [width-1:0] mem_rdata,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done
);
  localparam logic [CW:0] FD = (CW+1)'(fifo_depth);
  state_t state, state_n;
  logic [AW-1:0] ptr;
  logic [LW-1:0] rem, len_c;
  logic rd_d, last_d, issue, launch, hs_last;
  logic [CW-1:0] fifo_count;
  logic [CW:0] used;
  logic fifo_empty, fifo_full;
  logic [width:0] fifo_dout;
  assign len_c = (length > LW'(depth)) ? LW'(depth) : length;
  assign launch = state == IDLE && start && len_c != '0;
  // the read returning this cycle already owns a slot, so it is charged against the credit
  assign used = {1'b0, fifo_count} + {{CW{1'b0}}, rd_d};
  assign issue = state == READ && used < FD && !fifo_full;
  assign hs_last = m_valid && m_ready && m_last;
  assign mem_rd_en = issue;
  assign mem_addr = ptr;
  assign busy = state != IDLE;
  assign m_valid = !fifo_empty;
  assign m_data = fifo_dout[width-1:0];
  assign m_last = m_valid && fifo_dout[width];
  always_comb begin
    state_n = state;
    state_n = launch ? READ :
              (state == READ && issue && rem == LW'(1)) ? DRAIN :
              (state == DRAIN && hs_last) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= '0;
      rem <= '0;
      rd_d <= 1'b0;
      last_d <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      rd_d <= issue;
      last_d <= issue && rem == LW'(1);
      done <= (state == IDLE && start && len_c == '0) || (state == DRAIN && hs_last);
      if (launch) begin
        ptr <= base_addr;
        rem <= len_c;
      end else if (issue) begin
        ptr <= (ptr == AW'(depth - 1)) ? '0 : ptr + 1'b1;
        rem <= rem - 1'b1;
      end
    end
  end
  sync_fifo #(.width(width + 1), .depth(fifo_depth)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(rd_d),
    .din({last_d, mem_rdata}),
    .pop(m_valid && m_ready),
    .dout(fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_mem_stream_reader.sv
// tb_mem_stream_reader: randomized scoreboard bench with a memory model and transfer-level reference
module tb_mem_stream_reader;
  logic clk = 0, rst = 0, start = 0, m_ready = 0;
  logic [7:0] base_addr = 0, mem_addr;
  logic [8:0] length = 0;
  logic mem_rd_en, m_valid, m_last, busy, done;
  logic [31:0] mem_rdata = 0, m_data;
  logic [31:0] mem [256];
  logic [32:0] exp_q[$];
  logic [7:0] exp_addr_q[$];
  logic [32:0] prev_word;
  int checks = 0, errors = 0, cyc = 0;
  int ready_mode = 0, hold_zero = 0, pending_done = -1, t_start = 0;
  int rd_cnt = 0, hs_cnt = 0, max_out = 0, first_rd = -1, first_val = -1, last_hs = 0;
  bit first_word = 1, prev_stall = 0;

  mem_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event present, none expected (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    #2;
    if (hold_zero > 0) begin
      m_ready = 0;
      hold_zero--;
    end else m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? !m_ready : 1'($urandom_range(0, 1));
  end

  // monitor: every read address and every handshaken word is checked against the scoreboard
  always @(negedge clk) begin
    int cur;
    cur = cyc + 1;
    if (rst) begin
      if (dut.u_fifo.push) chk("fifo_no_overflow", dut.u_fifo.full, 0);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_word", {m_last, m_data}, prev_word);
      end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) flag("unexpected_read");
        else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
        chk("credit_limit", (rd_cnt + 1 - hs_cnt) <= 4, 1);
        if (rd_cnt + 1 - hs_cnt > max_out) max_out = rd_cnt + 1 - hs_cnt;
        rd_cnt++;
        if (first_rd < 0) first_rd = cur;
      end
      if (m_valid && first_val < 0) first_val = cur;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) flag("unexpected_word");
        else chk("word", {m_last, m_data}, exp_q.pop_front());
        if (ready_mode == 0 && !first_word) chk("back_to_back", cur, last_hs + 1);
        first_word = 0;
        last_hs = cur;
        hs_cnt++;
        if (m_last) pending_done = cur + 1;
      end
      if (done) begin
        if (pending_done < 0) flag("unexpected_done");
        else chk("done_cycle", cur, pending_done);
        chk("done_busy_low", busy, 0);
        pending_done = -1;
      end else if (pending_done >= 0 && cur > pending_done) begin
        chk("done_missing", 0, 1);
        pending_done = -1;
      end
      prev_stall = m_valid && !m_ready;
      prev_word = {m_last, m_data};
    end else prev_stall = 0;
  end

  task automatic run(input int base, input int len);
    int n;
    n = len > 256 ? 256 : len;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(8'((base + i) % 256));
      exp_q.push_back({i == n - 1, mem[(base + i) % 256]});
    end
    first_word = 1;
    base_addr = 8'(base);
    length = 9'(len);
    start = 1;
    @(posedge clk);
    #1;
    t_start = cyc;
    start = 0;
    if (n == 0) pending_done = t_start + 1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0 || pending_done >= 0 || busy) && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 4000) begin
      chk("transfer_timeout", n, 0);
      exp_q.delete();
      exp_addr_q.delete();
      pending_done = -1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h0, n;
    for (int a = 0; a < 256; a++) mem[a] = 32'(a + 'h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m_last", m_last, 0);
    @(posedge clk);
    #1;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    first_rd = -1;
    first_val = -1;
    run('h10, 4);
    wait_done();
    chk("first_rd_latency", first_rd, t_start + 1);
    chk("first_valid_latency", first_val, t_start + 3);
    run('hFE, 4);
    wait_done();
    ready_mode = 1;
    max_out = 0;
    run(0, 8);
    repeat (5) begin @(posedge clk); #1; end
    hold_zero = 10;
    wait_done();
    chk("credit_reaches_depth", max_out, 4);
    ready_mode = 0;
    run('h33, 0);
    wait_done();
    run('h80, 256);
    wait_done();
    run(5, 300);
    wait_done();
    ready_mode = 2;
    run('h20, 10);
    repeat (3) begin @(posedge clk); #1; end
    base_addr = 8'h40;
    length = 9'd3;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    wait_done();
    ready_mode = 0;
    h0 = hs_cnt;
    run('h50, 6);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 100) begin @(posedge clk); #1; n++; end
    chk("reset_wait_bound", n < 100, 1);
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    exp_q.delete();
    exp_addr_q.delete();
    pending_done = -1;
    rd_cnt = 0;
    hs_cnt = 0;
    @(negedge clk);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (4) @(posedge clk);
    #1;
    run('h30, 5);
    wait_done();
    for (int k = 0; k < 6; k++) begin
      ready_mode = 2;
      run($urandom_range(0, 255), $urandom_range(1, 24));
      wait_done();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
